// File: rtl/lbist_session_ctrl_if.sv
// Handshake and core-control bundle between the LBIST session sequencer and its host/core wrapper.
interface lbist_session_ctrl_if;
    localparam int unsigned CNT_W = 32;

    logic             start_i;
    logic             bypass_i;
    logic             abort_i;
    logic             go_nogo_i;
    logic             test_over_i;
    logic             core_rst_no;
    logic             test_mode_o;
    logic             normal_test_o;
    logic             clock_en_o;
    logic             fetch_enable_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic             fail_o;
    logic             timeout_o;
    logic [CNT_W-1:0] cycles_o;

    modport master (
        output start_i, bypass_i, abort_i, go_nogo_i, test_over_i,
        input  core_rst_no, test_mode_o, normal_test_o, clock_en_o, fetch_enable_o,
        input  busy_o, done_o, pass_o, fail_o, timeout_o, cycles_o
    );

    modport slave (
        input  start_i, bypass_i, abort_i, go_nogo_i, test_over_i,
        output core_rst_no, test_mode_o, normal_test_o, clock_en_o, fetch_enable_o,
        output busy_o, done_o, pass_o, fail_o, timeout_o, cycles_o
    );
endinterface

// File: rtl/lbist_session_ctrl.sv
// Sequences a core through reset, a logic-BIST session with timeout, verdict evaluation,
// and either a release into functional run or a park in reset.
module lbist_session_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 8,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1048576
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lbist_session_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_BIST_RST  = 3'd1;
    localparam logic [2:0] S_BIST_RUN  = 3'd2;
    localparam logic [2:0] S_BIST_EVAL = 3'd3;
    localparam logic [2:0] S_RUN_RST   = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_q, prev_d;
    logic              verdict_q, verdict_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              rst_n_q, rst_n_d;
    logic              test_mode_q, test_mode_d;
    logic              normal_q, normal_d;
    logic              clk_en_q, clk_en_d;
    logic              fetch_q, fetch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              to_rise;

    // Next-state, sticky status and registered-output decode
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        prev_d    = bus.test_over_i;
        verdict_d = verdict_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        to_rise   = bus.test_over_i & ~prev_q;

        if (bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start_i) begin
                        pass_d    = 1'b0;
                        fail_d    = 1'b0;
                        timeout_d = 1'b0;
                        cycles_d  = '0;
                        hold_d    = '0;
                        state_d   = bus.bypass_i ? S_RUN_RST : S_BIST_RST;
                    end
                end
                S_BIST_RST: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_BIST_RUN;
                        cnt_d   = '0;
                        // A test_over level already high at entry must not count as completion
                        prev_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                S_BIST_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (to_rise) begin
                        verdict_d = bus.go_nogo_i;
                        cycles_d  = cnt_q;
                        state_d   = S_BIST_EVAL;
                    end else if ((TIMEOUT_CYCLES != 32'd0) &&
                                 (cnt_q == TIMEOUT_CYCLES - 32'd1)) begin
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                        cycles_d  = TIMEOUT_CYCLES;
                        state_d   = S_HALT;
                    end
                end
                S_BIST_EVAL: begin
                    if (verdict_q) begin
                        pass_d  = 1'b1;
                        hold_d  = '0;
                        state_d = S_RUN_RST;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_HALT;
                    end
                end
                S_RUN_RST: begin
                    if (hold_q == HOLD_LAST) state_d = S_RUN;
                    else                     hold_d  = hold_q + HOLD_W'(1);
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end

        rst_n_d     = 1'b0;
        test_mode_d = 1'b0;
        normal_d    = 1'b0;
        clk_en_d    = 1'b0;
        fetch_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_BIST_RST: begin
                test_mode_d = 1'b1;
                normal_d    = 1'b1;
                busy_d      = 1'b1;
            end
            S_BIST_RUN: begin
                rst_n_d     = 1'b1;
                test_mode_d = 1'b1;
                normal_d    = 1'b1;
                clk_en_d    = 1'b1;
                busy_d      = 1'b1;
            end
            S_BIST_EVAL: begin
                rst_n_d     = 1'b1;
                test_mode_d = 1'b1;
                normal_d    = 1'b1;
                busy_d      = 1'b1;
            end
            S_RUN_RST: busy_d = 1'b1;
            S_RUN: begin
                rst_n_d  = 1'b1;
                clk_en_d = 1'b1;
                fetch_d  = 1'b1;
                done_d   = 1'b1;
            end
            S_HALT:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs; reset parks the core in reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            prev_q      <= 1'b1;
            verdict_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            rst_n_q     <= 1'b0;
            test_mode_q <= 1'b0;
            normal_q    <= 1'b0;
            clk_en_q    <= 1'b0;
            fetch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            verdict_q   <= verdict_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            rst_n_q     <= rst_n_d;
            test_mode_q <= test_mode_d;
            normal_q    <= normal_d;
            clk_en_q    <= clk_en_d;
            fetch_q     <= fetch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.core_rst_no    = rst_n_q;
    assign bus.test_mode_o    = test_mode_q;
    assign bus.normal_test_o  = normal_q;
    assign bus.clock_en_o     = clk_en_q;
    assign bus.fetch_enable_o = fetch_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.pass_o         = pass_q;
    assign bus.fail_o         = fail_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.cycles_o       = cycles_q;
endmodule
